// File: rtl/mux4_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated mux4 operand path.
// rr_pick returns {found, idx}: the first set req bit searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
package mux4_arb_pkg;

    localparam int N_REQ = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        FULL = 1'b1
    } arb_state_t;

    function automatic logic [2:0] rr_pick(input logic [N_REQ-1:0] req, input logic [1:0] ptr);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        // Walk from the farthest offset back to ptr so the nearest requester wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = ptr + 2'(k);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mux4.sv
// Plain 4:1 multiplexer; s selects which of d0..d3 appears on y.
module mux4 #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] y
);

    always_comb begin
        y = d0;
        case (s)
            2'd0: y = d0;
            2'd1: y = d1;
            2'd2: y = d2;
            2'd3: y = d3;
            default: y = d0;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arb.sv
// Round-robin arbiter sharing one mux4 among four requesters, with a single registered
// output stage. The current FSM state is visible on state_dbg.
//
// Handshakes: requester i transfers d<i> on a rising edge where req[i]=1 and gnt[i]=1
// (gnt acts as ready_i); the consumer takes y on a rising edge where y_valid=1 and
// y_ready=1. Requesters hold req/d stable until granted; y holds until consumed.
module mux4_rr_arb
    import mux4_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [3:0]       req,
    input  logic [WIDTH-1:0] d0,
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d2,
    input  logic [WIDTH-1:0] d3,
    output logic [3:0]       gnt,
    output logic [WIDTH-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output arb_state_t       state_dbg
);

    arb_state_t       state;
    logic [1:0]       ptr;
    logic [2:0]       pick;
    logic             found;
    logic [1:0]       winner;
    logic             load;
    logic [WIDTH-1:0] mux_y;

    assign pick   = rr_pick(req, ptr);
    assign found  = pick[2];
    assign winner = pick[1:0];

    // Decision uses only registered ptr/state plus live req/y_ready; y never depends on y_ready combinationally.
    assign load = found && ((state == IDLE) || y_ready);

    always_comb begin
        gnt = 4'b0000;
        if (reset_n && load) begin
            gnt = 4'b0001 << winner;
        end
    end

    mux4 #(.WIDTH(WIDTH)) u_mux4 (
        .d0 (d0),
        .d1 (d1),
        .d2 (d2),
        .d3 (d3),
        .s  (winner),
        .y  (mux_y)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= 2'd0;
            y     <= '0;
        end else if (load) begin
            y     <= mux_y;
            ptr   <= winner + 2'd1;
            state <= FULL;
        end else if ((state == FULL) && y_ready) begin
            state <= IDLE;
        end
    end

    assign y_valid   = (state == FULL);
    assign state_dbg = state;

endmodule

// File: tb/tb_mux4_rr_arb.sv
// Self-checking bench for mux4_rr_arb: directed scenarios followed by random traffic,
// with a reference model and an expected-data queue for y.
module tb_mux4_rr_arb;
    import mux4_arb_pkg::*;

    localparam int W = 6;

    logic         clk;
    logic         reset_n;
    logic [3:0]   req;
    logic [W-1:0] d0, d1, d2, d3;
    logic [3:0]   gnt;
    logic [W-1:0] y;
    logic         y_valid;
    logic         y_ready;
    arb_state_t   state_dbg;

    mux4_rr_arb #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .d0        (d0),
        .d1        (d1),
        .d2        (d2),
        .d3        (d3),
        .gnt       (gnt),
        .y         (y),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .state_dbg (state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // scoreboard state
    logic [W-1:0] exp_q[$];
    int           n_checks;
    int           n_errors;
    logic [1:0]   m_ptr;
    logic         m_full;
    logic [W-1:0] m_y;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ptr  = 2'd0;
        m_full = 1'b0;
        m_y    = '0;
        exp_q.delete();
    endtask

    // One clock cycle: inputs are already driven; checks gnt before the edge and
    // y/y_valid/state after it.
    task automatic step(input logic [3:0] want_gnt, input bit use_want);
        logic [W-1:0] dv[4];
        logic         m_load;
        logic         m_found;
        logic [1:0]   m_win;
        logic [1:0]   idx;
        logic [3:0]   m_gnt;
        logic [W-1:0] got;
        dv[0] = d0; dv[1] = d1; dv[2] = d2; dv[3] = d3;
        m_found = 1'b0;
        m_win   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            idx = m_ptr + 2'(k);
            if (!m_found && req[idx]) begin
                m_found = 1'b1;
                m_win   = idx;
            end
        end
        m_load = m_found && (!m_full || y_ready);
        m_gnt  = 4'b0000;
        if (m_load) m_gnt[m_win] = 1'b1;
        #1;
        check("gnt_model", 32'(gnt), 32'(m_gnt));
        if (use_want) check("gnt_plan", 32'(gnt), 32'(want_gnt));
        if (m_load) exp_q.push_back(dv[m_win]);
        @(posedge clk);
        if (m_load) begin
            m_ptr  = m_win + 2'd1;
            m_full = 1'b1;
        end else if (m_full && y_ready) begin
            m_full = 1'b0;
        end
        @(negedge clk);
        check("y_valid", 32'(y_valid), 32'(m_full));
        check("state_dbg", 32'(state_dbg), 32'(m_full));
        if (m_load) begin
            if (exp_q.size() == 0) begin
                check("exp_q_empty", 32'(1), 32'(0));
            end else begin
                got = exp_q.pop_front();
                m_y = got;
                check("y_data", 32'(y), 32'(got));
            end
        end else begin
            check("y_hold", 32'(y), 32'(m_y));
        end
    endtask

    task automatic drive(input logic [3:0] r, input logic rdy);
        req     = r;
        y_ready = rdy;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        model_reset();
        d0 = 6'h01; d1 = 6'h02; d2 = 6'h04; d3 = 6'h08;
        reset_n = 1'b0;
        drive(4'hF, 1'b1);

        // Reset state with all requests pending
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'(0));
        check("rst_y", 32'(y), 32'(0));
        check("rst_y_valid", 32'(y_valid), 32'(0));
        reset_n = 1'b1;
        step(4'b0001, 1'b1);
        check("rst_first_y", 32'(y), 32'(6'h01));

        // Rotation with all requesting
        step(4'b0010, 1'b1);
        step(4'b0100, 1'b1);
        step(4'b1000, 1'b1);
        step(4'b0001, 1'b1);
        check("rot_wrap_y", 32'(y), 32'(6'h01));

        // Backpressure on y=02
        step(4'b0010, 1'b1);
        drive(4'hF, 1'b0);
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);
        check("bp_y_held", 32'(y), 32'(6'h02));
        drive(4'hF, 1'b1);
        step(4'b0100, 1'b1);
        check("bp_release_y", 32'(y), 32'(6'h04));

        // Skip/wrap: ptr is 3 here
        drive(4'b0010, 1'b1);
        step(4'b0010, 1'b1);
        check("skip_y", 32'(y), 32'(6'h02));
        drive(4'b0001, 1'b1);
        step(4'b0001, 1'b1);
        check("wrap_y", 32'(y), 32'(6'h01));

        // Drain then idle
        drive(4'b0000, 1'b1);
        step(4'b0000, 1'b1);
        check("drain_valid", 32'(y_valid), 32'(0));
        check("drain_y", 32'(y), 32'(6'h01));
        for (int i = 0; i < 3; i++) step(4'b0000, 1'b1);

        // Async reset mid-stream
        drive(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        drive(4'b0000, 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        check("arst_y_valid", 32'(y_valid), 32'(0));
        check("arst_y", 32'(y), 32'(0));
        req = 4'hF;
        #1;
        check("arst_gnt", 32'(gnt), 32'(0));
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        drive(4'b1000, 1'b1);
        step(4'b1000, 1'b1);
        check("arst_after_y", 32'(y), 32'(6'h08));

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            d0 = W'($urandom_range(0, 63));
            d1 = W'($urandom_range(0, 63));
            d2 = W'($urandom_range(0, 63));
            d3 = W'($urandom_range(0, 63));
            drive(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
            step(4'b0000, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

endmodule
